branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL use one clock and one asynchronous, active-high reset; port names are clk and rst.
REQ-002 Ports SHALL be exactly as listed (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- id_branch_valid  in  1  resolved branch/jump present in ID this cycle
- id_branch_taken  in  1  branch_judge taken result
- id_branch_target  in  32  branch_judge target address
- id_branch_slot  in  1  0 = branch in master slot, 1 = branch in slave slot
- id_slave_valid  in  1  slave slot issues this cycle
- id_stall  in  1  ID held this cycle; branch not committed
- fb_ds_valid  in  1  fetch-buffer head holds the delay-slot instruction
- ex_flush  in  1  exception/eret flush
- if_ready  in  1  fetch accepts a redirect this cycle
- redirect_valid  out  1  redirect request to fetch
- redirect_pc  out  32  redirect target
- fb_flush  out  1  one-cycle fetch-buffer flush
- fb_keep_head  out  1  qualifies fb_flush: preserve head entry
- id_branch_block  out  1  ID SHALL NOT issue another branch
- perf_taken_cnt  out  32  committed taken-branch count

Function
REQ-003 A branch SHALL be accepted when id_branch_valid=1, id_branch_taken=1, id_stall=0, ex_flush=0, state=IDLE; not-taken or stalled branches SHALL cause no action.
REQ-004 States SHALL be IDLE, WAIT_DS, REDIRECT; state SHALL be registered.
REQ-005 Delay slot co-issued (slot=0 and id_slave_valid=1): IDLE->REDIRECT, keep_head flag=0.
REQ-006 Delay slot not co-issued (slot=1, or slot=0 with id_slave_valid=0): fb_ds_valid=1 -> REDIRECT with keep_head flag=1; fb_ds_valid=0 -> WAIT_DS.
REQ-007 WAIT_DS->REDIRECT, keep_head flag=1, in the first cycle fb_ds_valid=1.
REQ-008 Target SHALL be captured into a 32-bit register on acceptance; redirect_pc SHALL show it, stable, while state≠IDLE.
REQ-009 redirect_valid SHALL be 1 exactly while state=REDIRECT; earliest assertion is the cycle after acceptance.
REQ-010 Handshake: redirect_valid=1 and if_ready=1 completes; same cycle fb_flush=1, fb_keep_head=keep_head flag; next state IDLE.
REQ-011 fb_flush SHALL be 0 except on handshake cycle; fb_keep_head SHALL be 0 whenever fb_flush=0.
REQ-012 id_branch_block SHALL equal (state≠IDLE); branches presented in non-IDLE states SHALL be ignored.
REQ-013 ex_flush=1 SHALL force next state IDLE from any state, discard the pending target, suppress fb_flush that cycle, and block acceptance of a simultaneous branch.
REQ-014 perf_taken_cnt SHALL increment by 1 on each handshake completion, wrap 0xFFFFFFFF->0, not count discarded redirects.
REQ-015 Return to IDLE on handshake SHALL NOT accept a branch in that same cycle; next acceptance earliest the following cycle.

Reset
REQ-016 rst=1 SHALL asynchronously force state=IDLE, target=0, keep_head flag=0, perf_taken_cnt=0, so redirect_valid=0, redirect_pc=0, fb_flush=0, fb_keep_head=0, id_branch_block=0.
REQ-017 rst asserted mid-WAIT_DS or mid-REDIRECT SHALL drop redirect_valid immediately without a handshake or count.

Verification
REQ-018 Master-slot taken, target 0x8000_0100, slave_valid=1, if_ready=1 -> next cycle redirect_valid=1, redirect_pc=0x8000_0100, fb_flush=1, fb_keep_head=0; cnt 0->1.
REQ-019 Slave-slot taken, target 0xBFC0_0380, fb_ds_valid=0 for 3 cycles then 1 -> WAIT_DS 3 cycles, id_branch_block=1, then REDIRECT; handshake has fb_keep_head=1.
REQ-020 REDIRECT with if_ready=0 for 4 cycles -> redirect_valid and redirect_pc held 4 cycles, fb_flush=0; flush on 5th cycle with if_ready=1.
REQ-021 ex_flush=1 in WAIT_DS, simultaneous new taken branch -> IDLE next cycle, redirect_valid never asserts, cnt unchanged.
REQ-022 Preload cnt to 0xFFFFFFFF via 2^32-1 handshakes (or forced) -> next handshake gives 0x00000000.
REQ-023 rst pulse during REDIRECT -> all outputs 0 before next clock edge; taken branch with id_stall=1 -> no state change.

Source files
------------

// File: rtl/branch_redirect_ctrl_if.sv
// Signal bundle between ID/fetch-buffer/fetch and the branch redirect controller.
// The master side drives the branch and fetch status, and the slave side is the controller.
interface branch_redirect_ctrl_if;
  logic        id_branch_valid;
  logic        id_branch_taken;
  logic [31:0] id_branch_target;
  logic        id_branch_slot;
  logic        id_slave_valid;
  logic        id_stall;
  logic        fb_ds_valid;
  logic        ex_flush;
  logic        if_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fb_flush;
  logic        fb_keep_head;
  logic        id_branch_block;
  logic [31:0] perf_taken_cnt;

  modport master (
    output id_branch_valid, id_branch_taken, id_branch_target, id_branch_slot,
           id_slave_valid, id_stall, fb_ds_valid, ex_flush, if_ready,
    input  redirect_valid, redirect_pc, fb_flush, fb_keep_head, id_branch_block,
           perf_taken_cnt
  );

  modport slave (
    input  id_branch_valid, id_branch_taken, id_branch_target, id_branch_slot,
           id_slave_valid, id_stall, fb_ds_valid, ex_flush, if_ready,
    output redirect_valid, redirect_pc, fb_flush, fb_keep_head, id_branch_block,
           perf_taken_cnt
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// Sequences a taken branch into a fetch redirect once its delay slot is secured,
// then flushes the fetch buffer on the redirect handshake.
module branch_redirect_ctrl (
  input  logic                  clk,
  input  logic                  rst,
  branch_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_DS  = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] target_q;
  logic        keep_q;
  logic [31:0] cnt_q;

  logic accept;
  logic co_issue;
  logic handshake;

  always_comb begin
    accept    = (state == IDLE) & bus.id_branch_valid & bus.id_branch_taken &
                ~bus.id_stall & ~bus.ex_flush;
    co_issue  = ~bus.id_branch_slot & bus.id_slave_valid;
    handshake = (state == REDIRECT) & bus.if_ready & ~bus.ex_flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      target_q <= '0;
      keep_q   <= 1'b0;
      cnt_q    <= '0;
    end else if (bus.ex_flush) begin
      state    <= IDLE;
      target_q <= '0;
      keep_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            target_q <= bus.id_branch_target;
            // Keeping the head is needed whenever the delay slot sits in the buffer.
            keep_q   <= ~co_issue;
            state    <= (co_issue | bus.fb_ds_valid) ? REDIRECT : WAIT_DS;
          end
        end
        WAIT_DS: begin
          if (bus.fb_ds_valid) state <= REDIRECT;
        end
        REDIRECT: begin
          if (bus.if_ready) begin
            state    <= IDLE;
            target_q <= '0;
            keep_q   <= 1'b0;
            cnt_q    <= cnt_q + 32'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.redirect_valid  = (state == REDIRECT);
  assign bus.redirect_pc     = target_q;
  assign bus.fb_flush        = handshake;
  assign bus.fb_keep_head    = handshake & keep_q;
  assign bus.id_branch_block = (state != IDLE);
  assign bus.perf_taken_cnt  = cnt_q;
endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl: a pending-redirect model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_branch_redirect_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  branch_redirect_ctrl_if bus ();

  branch_redirect_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int checks   = 0;
  int failures = 0;
  logic preload = 1'b0;

  // Model: one optional pending redirect, and whether its delay slot is already secured.
  logic        m_pending = 1'b0;
  logic        m_ds      = 1'b0;
  logic [31:0] m_target  = '0;
  logic        m_keep    = 1'b0;
  logic [31:0] m_cnt     = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic hs;
    #4;
    if (preload) m_cnt = 32'hFFFF_FFFF;
    if (rst) begin
      chk("rst_redirect_valid", {31'b0, bus.redirect_valid}, 32'd0);
      chk("rst_redirect_pc", bus.redirect_pc, 32'd0);
      chk("rst_fb_flush", {31'b0, bus.fb_flush}, 32'd0);
      chk("rst_fb_keep_head", {31'b0, bus.fb_keep_head}, 32'd0);
      chk("rst_block", {31'b0, bus.id_branch_block}, 32'd0);
      chk("rst_cnt", bus.perf_taken_cnt, 32'd0);
      m_pending = 1'b0; m_ds = 1'b0; m_target = '0; m_keep = 1'b0; m_cnt = '0;
    end else begin
      hs = m_pending && m_ds && bus.if_ready && !bus.ex_flush;
      chk("m_redirect_valid", {31'b0, bus.redirect_valid}, {31'b0, m_pending && m_ds});
      chk("m_redirect_pc", bus.redirect_pc, m_pending ? m_target : 32'd0);
      chk("m_fb_flush", {31'b0, bus.fb_flush}, {31'b0, hs});
      chk("m_fb_keep_head", {31'b0, bus.fb_keep_head}, {31'b0, hs && m_keep});
      chk("m_block", {31'b0, bus.id_branch_block}, {31'b0, m_pending});
      chk("m_cnt", bus.perf_taken_cnt, m_cnt);
      if (bus.ex_flush) begin
        m_pending = 1'b0;
      end else if (m_pending) begin
        if (!m_ds) begin
          if (bus.fb_ds_valid) m_ds = 1'b1;
        end else if (bus.if_ready) begin
          m_pending = 1'b0;
          m_cnt = m_cnt + 32'd1;
        end
      end else if (bus.id_branch_valid && bus.id_branch_taken && !bus.id_stall) begin
        m_pending = 1'b1;
        m_target  = bus.id_branch_target;
        m_keep    = !(!bus.id_branch_slot && bus.id_slave_valid);
        m_ds      = !m_keep || bus.fb_ds_valid;
      end
    end
  end

  task automatic drive(input logic v, input logic t, input logic [31:0] tgt,
                       input logic s, input logic sv, input logic st,
                       input logic ds, input logic exf, input logic rdy);
    @(negedge clk);
    bus.id_branch_valid  = v;
    bus.id_branch_taken  = t;
    bus.id_branch_target = tgt;
    bus.id_branch_slot   = s;
    bus.id_slave_valid   = sv;
    bus.id_stall         = st;
    bus.fb_ds_valid      = ds;
    bus.ex_flush         = exf;
    bus.if_ready         = rdy;
  endtask

  task automatic idle(input logic ds, input logic exf, input logic rdy);
    drive(1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, ds, exf, rdy);
  endtask

  initial begin
    bus.id_branch_valid = 1'b0; bus.id_branch_taken = 1'b0; bus.id_branch_target = '0;
    bus.id_branch_slot = 1'b0; bus.id_slave_valid = 1'b0; bus.id_stall = 1'b0;
    bus.fb_ds_valid = 1'b0; bus.ex_flush = 1'b0; bus.if_ready = 1'b0;
    repeat (2) idle(1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Master-slot branch with co-issued delay slot, immediate handshake
    drive(1'b1, 1'b1, 32'h8000_0100, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    #4;
    chk("l18_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("l18_pc", bus.redirect_pc, 32'h8000_0100);
    chk("l18_flush", {31'b0, bus.fb_flush}, 32'd1);
    chk("l18_keep", {31'b0, bus.fb_keep_head}, 32'd0);
    idle(1'b0, 1'b0, 1'b1);
    #4 chk("l18_cnt", bus.perf_taken_cnt, 32'd1);

    // Slave-slot branch waiting three cycles for the delay slot
    drive(1'b1, 1'b1, 32'hBFC0_0380, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      idle(1'b0, 1'b0, 1'b1);
      #4;
      chk("l19_wait_block", {31'b0, bus.id_branch_block}, 32'd1);
      chk("l19_wait_valid", {31'b0, bus.redirect_valid}, 32'd0);
    end
    idle(1'b1, 1'b0, 1'b1);
    #4 chk("l19_ds_valid", {31'b0, bus.redirect_valid}, 32'd0);
    idle(1'b0, 1'b0, 1'b1);
    #4;
    chk("l19_valid", {31'b0, bus.redirect_valid}, 32'd1);
    chk("l19_pc", bus.redirect_pc, 32'hBFC0_0380);
    chk("l19_flush", {31'b0, bus.fb_flush}, 32'd1);
    chk("l19_keep", {31'b0, bus.fb_keep_head}, 32'd1);

    // Delay slot already in buffer, fetch stalls four cycles
    drive(1'b1, 1'b1, 32'h0040_0000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b0, 1'b0, 1'b0);
      #4;
      chk("l20_hold_valid", {31'b0, bus.redirect_valid}, 32'd1);
      chk("l20_hold_pc", bus.redirect_pc, 32'h0040_0000);
      chk("l20_hold_flush", {31'b0, bus.fb_flush}, 32'd0);
    end
    idle(1'b0, 1'b0, 1'b1);
    #4;
    chk("l20_flush", {31'b0, bus.fb_flush}, 32'd1);
    chk("l20_keep", {31'b0, bus.fb_keep_head}, 32'd1);
    idle(1'b0, 1'b0, 1'b0);
    #4 chk("l20_cnt", bus.perf_taken_cnt, 32'd3);

    // Exception flush in WAIT_DS with a simultaneous taken branch
    drive(1'b1, 1'b1, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'h0000_ABCD, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    #4 chk("l21_flush_cycle", {31'b0, bus.fb_flush}, 32'd0);
    idle(1'b1, 1'b0, 1'b1);
    #4;
    chk("l21_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("l21_block", {31'b0, bus.id_branch_block}, 32'd0);
    idle(1'b0, 1'b0, 1'b1);
    #4 chk("l21_cnt", bus.perf_taken_cnt, 32'd3);

    // Exception flush during REDIRECT suppresses the flush and the count
    drive(1'b1, 1'b1, 32'h2222_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b1, 1'b1);
    #4 chk("lex_flush", {31'b0, bus.fb_flush}, 32'd0);
    idle(1'b0, 1'b0, 1'b1);
    #4;
    chk("lex_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("lex_cnt", bus.perf_taken_cnt, 32'd3);

    // Branch presented on the handshake cycle is ignored
    drive(1'b1, 1'b1, 32'h3333_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    drive(1'b1, 1'b1, 32'h4444_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    #4 chk("l15_flush", {31'b0, bus.fb_flush}, 32'd1);
    idle(1'b0, 1'b0, 1'b1);
    #4;
    chk("l15_block", {31'b0, bus.id_branch_block}, 32'd0);
    chk("l15_cnt", bus.perf_taken_cnt, 32'd4);

    // Stalled and not-taken branches
    drive(1'b1, 1'b1, 32'h5555_0000, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    #4 chk("lstall_block", {31'b0, bus.id_branch_block}, 32'd0);
    drive(1'b1, 1'b0, 32'h5555_0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    #4 chk("lnt_block", {31'b0, bus.id_branch_block}, 32'd0);

    // Reset pulse mid-REDIRECT
    drive(1'b1, 1'b1, 32'h6666_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1'b0, 1'b0);
    #1 chk("l23_pre_valid", {31'b0, bus.redirect_valid}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("l23_valid", {31'b0, bus.redirect_valid}, 32'd0);
    chk("l23_pc", bus.redirect_pc, 32'd0);
    chk("l23_block", {31'b0, bus.id_branch_block}, 32'd0);
    chk("l23_cnt", bus.perf_taken_cnt, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Counter wrap from a preloaded all-ones value
    idle(1'b0, 1'b0, 1'b1);
    preload = 1'b1;
    force dut.cnt_q = 32'hFFFF_FFFF;
    idle(1'b0, 1'b0, 1'b1);
    release dut.cnt_q;
    preload = 1'b0;
    #4 chk("l22_preload", bus.perf_taken_cnt, 32'hFFFF_FFFF);
    drive(1'b1, 1'b1, 32'h7777_0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1'b0, 1'b0, 1'b1);
    #4 chk("l22_flush", {31'b0, bus.fb_flush}, 32'd1);
    idle(1'b0, 1'b0, 1'b1);
    #4 chk("l22_wrap", bus.perf_taken_cnt, 32'd0);

    repeat (2) idle(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
